// File: rtl/reg_file_wb_if.sv
// Decode/write-back side bus of the integer register file: write-back commit,
// two bypassed read ports and the pending-write scoreboard.
interface reg_file_wb_if #(
  parameter int XLEN = 32
);
  logic            Stall;
  logic            flush;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            sb_set;
  logic [4:0]      sb_set_rd;
  logic            rs1_busy;
  logic            rs2_busy;
  logic [5:0]      pend_cnt;

  modport master (
    output Stall, flush, wb_en, wb_rd, wb_data, rs1_addr, rs2_addr, sb_set, sb_set_rd,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, pend_cnt
  );

  modport slave (
    input  Stall, flush, wb_en, wb_rd, wb_data, rs1_addr, rs2_addr, sb_set, sb_set_rd,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, pend_cnt
  );
endinterface

// File: rtl/reg_file_wb.sv
// Architectural register file with write-through bypass and a pending-write
// scoreboard (per-register busy bits plus a registered popcount).
module reg_file_wb #(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_wb_if.slave  bus
);

  logic [XLEN-1:0]    regs_q [REG_NUM];
  logic [REG_NUM-1:0] pend_q, pend_d;
  logic [5:0]         cnt_q, cnt_d;
  logic               wr_hit, set_hit, inc, dec;

  assign wr_hit  = bus.wb_en && (bus.wb_rd != 5'd0);
  assign set_hit = bus.sb_set && !bus.Stall && !bus.flush && (bus.sb_set_rd != 5'd0);

  // Set beats clear on the same index: the newly issued producer owns the bit.
  assign inc = set_hit && !pend_q[bus.sb_set_rd];
  assign dec = wr_hit && pend_q[bus.wb_rd] && !(set_hit && (bus.sb_set_rd == bus.wb_rd));

  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q + {5'd0, inc} - {5'd0, dec};
    if (wr_hit)  pend_d[bus.wb_rd]     = 1'b0;
    if (set_hit) pend_d[bus.sb_set_rd] = 1'b1;
    if (bus.flush) begin
      pend_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_hit) regs_q[bus.wb_rd] <= bus.wb_data;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    bus.rs1_data = regs_q[bus.rs1_addr];
    if (bus.wb_en && (bus.wb_rd == bus.rs1_addr)) bus.rs1_data = bus.wb_data;
    if (bus.rs1_addr == 5'd0) bus.rs1_data = '0;
  end

  always_comb begin
    bus.rs2_data = regs_q[bus.rs2_addr];
    if (bus.wb_en && (bus.wb_rd == bus.rs2_addr)) bus.rs2_data = bus.wb_data;
    if (bus.rs2_addr == 5'd0) bus.rs2_data = '0;
  end

  // A write presented this cycle resolves the hazard immediately via bypass.
  assign bus.rs1_busy = (bus.rs1_addr != 5'd0) && pend_q[bus.rs1_addr]
                        && !(bus.wb_en && (bus.wb_rd == bus.rs1_addr));
  assign bus.rs2_busy = (bus.rs2_addr != 5'd0) && pend_q[bus.rs2_addr]
                        && !(bus.wb_en && (bus.wb_rd == bus.rs2_addr));
  assign bus.pend_cnt = cnt_q;

endmodule
